// File: rtl/uart_rx_if.sv
// Serial input and received-byte handshake bundle for uart_rx.
// master = receiver side, slave = consumer/line driver side.
interface uart_rx_if;
    logic       rx_pin;
    logic [7:0] recv_data;
    logic       recv_valid;
    logic       recv_ready;
    logic       frame_err;
    logic       overrun;

    modport master (
        input  rx_pin,
        input  recv_ready,
        output recv_data,
        output recv_valid,
        output frame_err,
        output overrun
    );

    modport slave (
        output rx_pin,
        output recv_ready,
        input  recv_data,
        input  recv_valid,
        input  frame_err,
        input  overrun
    );
endinterface

// File: rtl/uart_rx.sv
// UART receiver, 8N1 LSB first, mid-bit sampling, valid/ready byte output.
// Optional UART_RX_MAJORITY_EN: 2-of-3 majority vote around each sample point.
//
// state | meaning
// IDLE  | waiting for a 1->0 edge on the synchronised line
// START | counting to start-bit middle, rejecting glitches
// DATA  | sampling 8 data bits, one per bit period
// STOP  | sampling stop bit, delivering byte or flagging error
module uart_rx #(
    parameter int CLK_FRE   = 50,
    parameter int UART_RATE = 115200
) (
    input  logic      clk,
    input  logic      rst,
    uart_rx_if.master bus
);
    localparam logic [10:0] RATE_CNT = 11'((CLK_FRE * 1000000 / UART_RATE) - 1);
    localparam logic [10:0] HALF_CNT = RATE_CNT >> 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic       sync1_q, rx_s_q, rx_d_q;
    logic [1:0] state_q, state_d;
    logic [10:0] clk_cnt_q, clk_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] recv_data_q, recv_data_d;
    logic       recv_valid_q, recv_valid_d;
    logic       frame_err_q, frame_err_d;
    logic       overrun_q, overrun_d;
    logic       sample;

`ifdef UART_RX_MAJORITY_EN
    // Decision one cycle late so the vote sees cnt-1, cnt, cnt+1; reload at 1 keeps spacing.
    localparam logic [10:0] START_PT   = HALF_CNT + 11'd1;
    localparam logic [10:0] BIT_PT     = RATE_CNT + 11'd1;
    localparam logic [10:0] CNT_RELOAD = 11'd1;

    logic rx_dd_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rx_dd_q <= 1'b1;
        else     rx_dd_q <= rx_d_q;
    end

    assign sample = (rx_s_q & rx_d_q) | (rx_s_q & rx_dd_q) | (rx_d_q & rx_dd_q);
`else
    localparam logic [10:0] START_PT   = HALF_CNT;
    localparam logic [10:0] BIT_PT     = RATE_CNT;
    localparam logic [10:0] CNT_RELOAD = 11'd0;

    assign sample = rx_s_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
            rx_d_q  <= 1'b1;
        end else begin
            sync1_q <= bus.rx_pin;
            rx_s_q  <= sync1_q;
            rx_d_q  <= rx_s_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        clk_cnt_d    = clk_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        recv_data_d  = recv_data_q;
        recv_valid_d = recv_valid_q & ~bus.recv_ready;
        frame_err_d  = 1'b0;
        overrun_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (rx_d_q && !rx_s_q) begin
                    clk_cnt_d = 11'd0;
                    state_d   = START;
                end
            end
            START: begin
                if (clk_cnt_q == START_PT) begin
                    if (!sample) begin
                        clk_cnt_d = CNT_RELOAD;
                        bit_cnt_d = 3'd0;
                        state_d   = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 11'd1;
                end
            end
            DATA: begin
                if (clk_cnt_q == BIT_PT) begin
                    shift_d[bit_cnt_q] = sample;
                    clk_cnt_d          = CNT_RELOAD;
                    bit_cnt_d          = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = STOP;
                end else begin
                    clk_cnt_d = clk_cnt_q + 11'd1;
                end
            end
            STOP: begin
                if (clk_cnt_q == BIT_PT) begin
                    state_d   = IDLE;
                    clk_cnt_d = 11'd0;
                    if (!sample) begin
                        frame_err_d = 1'b1;
                    end else if (!recv_valid_q || bus.recv_ready) begin
                        recv_data_d  = shift_q;
                        recv_valid_d = 1'b1;
                    end else begin
                        overrun_d = 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + 11'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            clk_cnt_q    <= 11'd0;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'd0;
            recv_data_q  <= 8'd0;
            recv_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            recv_data_q  <= recv_data_d;
            recv_valid_q <= recv_valid_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign bus.recv_data  = recv_data_q;
    assign bus.recv_valid = recv_valid_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 50 MHz / 115200 baud (434 clocks per bit).
// Inputs change 2 time units after posedge; monitor observes on negedge.
module tb_uart_rx;
    localparam int BIT_CLK = 434;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    uart_rx_if u_if ();

    uart_rx #(
        .CLK_FRE   (50),
        .UART_RATE (115200)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] got_q[$];
    int         fe_cnt;
    int         ov_cnt;
    int         vhigh_cnt;

    initial begin
        fe_cnt    = 0;
        ov_cnt    = 0;
        vhigh_cnt = 0;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (u_if.recv_valid && u_if.recv_ready) got_q.push_back(u_if.recv_data);
            if (u_if.frame_err)  fe_cnt    = fe_cnt + 1;
            if (u_if.overrun)    ov_cnt    = ov_cnt + 1;
            if (u_if.recv_valid) vhigh_cnt = vhigh_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (obs !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic send_bit(input logic b, input bit glitch);
        for (int i = 0; i < BIT_CLK; i++) begin
            u_if.rx_pin = (glitch && i == 216) ? ~b : b;
            wait_clk(1);
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop_b, input bit glitch);
        send_bit(1'b0, glitch);
        for (int i = 0; i < 8; i++) send_bit(data[i], glitch);
        send_bit(stop_b, glitch);
    endtask

    int q0, fe0, ov0, vh0;

    task automatic mark();
        q0  = got_q.size();
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        vh0 = vhigh_cnt;
    endtask

    initial begin
        n_tests         = 0;
        n_fail          = 0;
        rst             = 1'b1;
        u_if.rx_pin     = 1'b1;
        u_if.recv_ready = 1'b1;
        wait_clk(5);
        chk("rst_data",  u_if.recv_data,  8'h00);
        chk("rst_valid", u_if.recv_valid, 1'b0);
        chk("rst_ferr",  u_if.frame_err,  1'b0);
        chk("rst_ovr",   u_if.overrun,    1'b0);
        rst = 1'b0;
        wait_clk(20);

        // 1: single byte, consumer always ready
        mark();
        send_frame(8'hA5, 1'b1, 1'b0);
        wait_clk(10);
        chk("s1_count", got_q.size() - q0, 1);
        if (got_q.size() > q0) chk("s1_data", got_q[q0], 8'hA5);
        chk("s1_vwidth", vhigh_cnt - vh0, 1);
        chk("s1_ferr", fe_cnt - fe0, 0);
        chk("s1_ovr",  ov_cnt - ov0, 0);

        // 2: back-to-back frames
        mark();
        send_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0);
        wait_clk(10);
        chk("s2_count", got_q.size() - q0, 3);
        if (got_q.size() >= q0 + 3) begin
            chk("s2_b0", got_q[q0],     8'h00);
            chk("s2_b1", got_q[q0 + 1], 8'hFF);
            chk("s2_b2", got_q[q0 + 2], 8'h3C);
        end
        chk("s2_errs", (fe_cnt - fe0) + (ov_cnt - ov0), 0);

        // 3: short low glitch on idle line
        mark();
        u_if.rx_pin = 1'b0;
        wait_clk(100);
        u_if.rx_pin = 1'b1;
        wait_clk(600);
        chk("s3_noval",  vhigh_cnt - vh0, 0);
        chk("s3_noferr", fe_cnt - fe0, 0);
        send_frame(8'h55, 1'b1, 1'b0);
        wait_clk(10);
        chk("s3_count", got_q.size() - q0, 1);
        if (got_q.size() > q0) chk("s3_data", got_q[q0], 8'h55);

        // 4: stop bit low
        mark();
        send_frame(8'h81, 1'b0, 1'b0);
        wait_clk(10);
        chk("s4_ferr",  fe_cnt - fe0, 1);
        chk("s4_noval", vhigh_cnt - vh0, 0);
        u_if.rx_pin = 1'b1;
        wait_clk(BIT_CLK);
        send_frame(8'h12, 1'b1, 1'b0);
        wait_clk(10);
        chk("s4_count", got_q.size() - q0, 1);
        if (got_q.size() > q0) chk("s4_data", got_q[q0], 8'h12);

        // 5: overrun while consumer stalls
        mark();
        u_if.recv_ready = 1'b0;
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        wait_clk(10);
        chk("s5_ovr",   ov_cnt - ov0, 1);
        chk("s5_held",  u_if.recv_data,  8'h11);
        chk("s5_valid", u_if.recv_valid, 1'b1);
        chk("s5_nopop", got_q.size() - q0, 0);
        u_if.recv_ready = 1'b1;
        wait_clk(1);
        chk("s5_vdrop", u_if.recv_valid, 1'b0);
        chk("s5_count", got_q.size() - q0, 1);
        if (got_q.size() > q0) chk("s5_acc", got_q[q0], 8'h11);

        // 6: reset in the middle of bit 4
        mark();
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(i[0], 1'b0);
        u_if.rx_pin = 1'b0;
        wait_clk(217);
        rst         = 1'b1;
        u_if.rx_pin = 1'b1;
        #1;
        chk("s6_rdata",  u_if.recv_data,  8'h00);
        chk("s6_rvalid", u_if.recv_valid, 1'b0);
        wait_clk(5);
        rst = 1'b0;
        wait_clk(1000);
        chk("s6_nopart", got_q.size() - q0, 0);
        send_frame(8'hC3, 1'b1, 1'b0);
        wait_clk(10);
        chk("s6_count", got_q.size() - q0, 1);
        if (got_q.size() > q0) chk("s6_data", got_q[q0], 8'hC3);

`ifdef UART_RX_MAJORITY_EN
        // 1-clk inverted glitch at every mid-bit is outvoted
        mark();
        send_frame(8'hA5, 1'b1, 1'b1);
        wait_clk(10);
        chk("mj_count", got_q.size() - q0, 1);
        if (got_q.size() > q0) chk("mj_data", got_q[q0], 8'hA5);
        chk("mj_ferr", fe_cnt - fe0, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
